// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV32I core: sequences the shared ALU and the
// unified memory port one instruction at a time, with a memory-wait timeout.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       branch_cond_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       pc_src_o,
  output logic       illegal_o,
  output logic       bus_error_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_EXEC_U    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_HALT      = 4'd11
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_OP_R   = 3'b000;
  localparam logic [2:0] ALU_OP_IS  = 3'b001;
  localparam logic [2:0] ALU_OP_U   = 3'b010;
  localparam logic [2:0] ALU_OP_ADD = 3'b011;
  localparam logic [2:0] ALU_OP_B   = 3'b100;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;
  logic             mem_state;
  logic             opc_legal;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);

  always_comb begin
    opc_legal = 1'b1;
    unique case (opcode_i)
      OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_BRANCH: opc_legal = 1'b1;
      default:                                                opc_legal = 1'b0;
    endcase
  end

  // Next-state, wait counter and sticky bus-error update
  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OPC_R:                state_d = S_EXEC_R;
          OPC_I:                state_d = S_EXEC_I;
          OPC_LOAD, OPC_STORE:  state_d = S_MEM_ADDR;
          OPC_LUI:              state_d = S_EXEC_U;
          OPC_BRANCH:           state_d = S_BRANCH;
          default:              state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_U: state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode_i == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready_i) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase

    // A ready on the terminal-count cycle takes priority over the timeout
    if (mem_state && !mem_ready_i && (cnt_q == TERM_CNT)) begin
      state_d     = S_HALT;
      bus_error_d = 1'b1;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_state && !mem_ready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Moore decode of the datapath controls; only the handshake-qualified
  // enables look at live inputs so they can fire on the ready cycle.
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = SRC_A_PC;
    alu_src_b_o  = SRC_B_RS2;
    alu_op_o     = ALU_OP_ADD;
    pc_src_o     = 1'b0;
    illegal_o    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_a_o = SRC_A_PC;
        alu_src_b_o = SRC_B_FOUR;
        pc_write_o  = mem_ready_i;
        ir_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        illegal_o   = !opc_legal;
      end
      S_EXEC_R: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_RS2;
        alu_op_o    = ALU_OP_R;
      end
      S_EXEC_I: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_IS;
      end
      S_EXEC_U: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_U;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_IS;
      end
      S_MEM_READ: begin
        i_or_d_o   = 1'b1;
        mem_read_o = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WRITE: begin
        i_or_d_o    = 1'b1;
        mem_write_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_RS2;
        alu_op_o    = ALU_OP_B;
        pc_src_o    = 1'b1;
        pc_write_o  = branch_cond_i;
      end
      default: ;
    endcase
  end

  assign bus_error_o = bus_error_q;
  assign state_o     = state_q;

endmodule
